// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at dispatch, captures writebacks, retires up to RETIRE_WIDTH per cycle.
// Retire outputs are registered one cycle after eligibility; dispatch is refused while free entries < DISPATCH_WIDTH.
module reorder_buffer #(
    parameter int ROB_DEPTH      = 32,
    parameter int DISPATCH_WIDTH = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int NUM_CPL        = 3,
    parameter int AREG_W         = 5,
    parameter int IDX_W          = $clog2(ROB_DEPTH),
    parameter int RCNT_W         = $clog2(RETIRE_WIDTH+1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_en,
    input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
    input  logic [DISPATCH_WIDTH-1:0]        disp_has_dst,
    input  logic [DISPATCH_WIDTH*AREG_W-1:0] disp_dest_reg,
    output logic                             disp_ready,
    output logic [DISPATCH_WIDTH*IDX_W-1:0]  disp_rob_idx,
    input  logic [NUM_CPL-1:0]               cpl_valid,
    input  logic [NUM_CPL*IDX_W-1:0]         cpl_rob_idx,
    input  logic [NUM_CPL*32-1:0]            cpl_val,
    output logic [RETIRE_WIDTH-1:0]          ret_valid,
    output logic [RETIRE_WIDTH*AREG_W-1:0]   ret_dest_reg,
    output logic [RETIRE_WIDTH*32-1:0]       ret_result,
    output logic [RCNT_W-1:0]                ret_cnt,
    output logic                             rob_empty,
    output logic                             rob_full
);
    localparam int CNT_W = IDX_W + 1;

    logic [ROB_DEPTH-1:0]    alloc_q;
    logic [ROB_DEPTH-1:0]    done_q;
    logic [ROB_DEPTH-1:0]    has_dst_q;
    logic [AREG_W-1:0]       dest_q [ROB_DEPTH];
    logic [31:0]             val_q  [ROB_DEPTH];

    logic [IDX_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [RETIRE_WIDTH-1:0]          ret_valid_q, ret_valid_d;
    logic [RETIRE_WIDTH*AREG_W-1:0]   ret_dest_q, ret_dest_d;
    logic [RETIRE_WIDTH*32-1:0]       ret_result_q, ret_result_d;
    logic [RCNT_W-1:0]                ret_cnt_q, ret_cnt_d;

    logic [DISPATCH_WIDTH-1:0] disp_acc;
    logic [CNT_W-1:0]          n_disp;
    logic [IDX_W-1:0]          disp_idx [DISPATCH_WIDTH];
    logic [IDX_W-1:0]          ridx [RETIRE_WIDTH];
    logic [RCNT_W-1:0]         n_ret;
    logic                      scan_stop;

    always_comb begin
        disp_ready = (count_q <= CNT_W'(ROB_DEPTH - DISPATCH_WIDTH));
        disp_acc   = disp_valid & {DISPATCH_WIDTH{disp_ready}};
        n_disp     = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            disp_idx[i] = tail_q + IDX_W'(i);
            disp_rob_idx[i*IDX_W +: IDX_W] = disp_idx[i];
            n_disp = n_disp + CNT_W'(disp_acc[i]);
        end
    end

    // Scan stops at the first entry that is not both allocated and done.
    always_comb begin
        n_ret     = '0;
        scan_stop = 1'b0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ridx[k] = head_q + IDX_W'(k);
            if (!scan_stop && alloc_q[ridx[k]] && done_q[ridx[k]])
                n_ret = n_ret + RCNT_W'(1);
            else
                scan_stop = 1'b1;
        end
    end

    always_comb begin
        head_d       = head_q + IDX_W'(n_ret);
        tail_d       = tail_q + IDX_W'(n_disp);
        count_d      = count_q + n_disp - CNT_W'(n_ret);
        ret_cnt_d    = n_ret;
        ret_valid_d  = '0;
        ret_dest_d   = '0;
        ret_result_d = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (RCNT_W'(k) < n_ret) begin
                ret_valid_d[k]                  = has_dst_q[ridx[k]];
                ret_dest_d[k*AREG_W +: AREG_W]  = dest_q[ridx[k]];
                ret_result_d[k*32 +: 32]        = val_q[ridx[k]];
            end
        end
        if (flush_en) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            ret_cnt_d   = '0;
            ret_valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ret_valid_q  <= '0;
            ret_dest_q   <= '0;
            ret_result_q <= '0;
            ret_cnt_q    <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ret_valid_q  <= ret_valid_d;
            ret_dest_q   <= ret_dest_d;
            ret_result_q <= ret_result_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

    // Retire clears are applied last so they win over a late completion on the same entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_q <= '0;
            done_q  <= '0;
        end else if (flush_en) begin
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_CPL; p++) begin
                if (cpl_valid[p] && alloc_q[cpl_rob_idx[p*IDX_W +: IDX_W]])
                    done_q[cpl_rob_idx[p*IDX_W +: IDX_W]] <= 1'b1;
            end
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (disp_acc[i]) begin
                    alloc_q[disp_idx[i]] <= 1'b1;
                    done_q[disp_idx[i]]  <= 1'b0;
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (RCNT_W'(k) < n_ret) begin
                    alloc_q[ridx[k]] <= 1'b0;
                    done_q[ridx[k]]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_en) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (disp_acc[i]) begin
                    has_dst_q[disp_idx[i]] <= disp_has_dst[i];
                    dest_q[disp_idx[i]]    <= disp_dest_reg[i*AREG_W +: AREG_W];
                end
            end
            for (int p = 0; p < NUM_CPL; p++) begin
                if (cpl_valid[p] && alloc_q[cpl_rob_idx[p*IDX_W +: IDX_W]])
                    val_q[cpl_rob_idx[p*IDX_W +: IDX_W]] <= cpl_val[p*32 +: 32];
            end
        end
    end

    assign ret_valid    = ret_valid_q;
    assign ret_dest_reg = ret_dest_q;
    assign ret_result   = ret_result_q;
    assign ret_cnt      = ret_cnt_q;
    assign rob_empty    = (count_q == '0);
    assign rob_full     = (count_q == CNT_W'(ROB_DEPTH));
endmodule
